hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit operands and 64-bit HI:LO.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; accepted only on an edge where busy=0.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-006 a  input  32  rs operand, dividend or multiplicand, MTHI/MTLO source.
REQ-007 b  input  32  rt operand, divisor or multiplier.
REQ-008 hi  output  32  HI register, driven directly from a flop.
REQ-009 lo  output  32  LO register, driven directly from a flop.
REQ-010 busy  output  1  high while a divide is in progress.
REQ-011 done  output  1  one-cycle pulse when HI/LO have just been updated by an accepted op.

Function
REQ-012 The FSM SHALL have states IDLE and DIV; busy SHALL equal (state==DIV).
REQ-013 Accept edge E0 (start=1, busy=0, op 000-101): operands SHALL be captured; start with busy=1 SHALL be ignored without error.
REQ-014 MULT: {hi,lo} SHALL load the signed 64-bit product at E0; done=1 in the following cycle; state stays IDLE.
REQ-015 MULTU: as MULT, unsigned product.
REQ-016 MTHI: hi SHALL load a at E0 and lo SHALL hold; MTLO: lo SHALL load a at E0 and hi SHALL hold; both pulse done next cycle.
REQ-017 DIV/DIVU: E0 SHALL latch operand magnitudes and result signs and enter DIV; HI/LO SHALL hold old values while busy.
REQ-018 The divider SHALL be radix-2 restoring, one quotient bit per edge, edges E1..E32; at E32 lo SHALL load the quotient and hi the remainder, state returns to IDLE, and done=1 in the cycle after E32 (busy=0 that cycle).
REQ-019 DIV signs: quotient negative iff a[31]^b[31]; remainder takes the sign of a; magnitudes computed unsigned on 32 bits.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (no trap, no flag).
REQ-021 Divide by zero (b=0, DIV or DIVU) SHALL run the full 32 cycles and give lo=0xFFFFFFFF, hi=a.
REQ-022 A start on the same edge where done is asserted (busy=0) SHALL be accepted normally; back-to-back ops SHALL have no bubble.
REQ-023 op 110/111 with start=1 SHALL change nothing and SHALL NOT pulse done.
REQ-024 Operand changes on a/b after E0 SHALL NOT affect an in-progress divide.

Reset
REQ-025 While rst=1: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0, asynchronously.
REQ-026 Reset asserted mid-divide SHALL abort the divide with no partial result written; first accepted start after release behaves as from power-up.

Structure
REQ-027 A shared package hilo_pkg SHALL hold op encodings, FSM state encoding, and the 32-cycle iteration count constant.
REQ-028 One sub-module div_step SHALL implement a single combinational restoring step (remainder, quotient shift, divisor in; next remainder, next quotient out), instantiated once and reused each cycle.
REQ-029 Total RTL SHALL not exceed 400 lines; no latches; hi/lo updated from one always block.

Verification
REQ-030 Reset: rst pulse mid-cycle with prior hi=0x1234 -> hi=lo=0, busy=0, done=0 immediately.
REQ-031 MULT a=0xFFFFFFFE(-2), b=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1, busy never 1; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> busy high 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done one cycle; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-033 DIVU a=5, b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start MULT issued at cycle 10 of a divide -> ignored, divide result unchanged; MTLO a=0xABCD issued in the done cycle -> lo=0xABCD next edge, hi keeps remainder.
REQ-035 Reset asserted at divide cycle 16 -> hi=lo=0, busy=0, no done pulse; subsequent DIVU 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states, divider iteration count and operand helpers.
package hilo_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_NOP6  = 3'b110,
      OP_NOP7  = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DIV  = 1'b1
   } state_e;

   localparam int unsigned DIV_CYCLES = 32;
   localparam int          CNT_W      = 5;

   function automatic logic op_is_valid(input op_e op);
      return (op != OP_NOP6) && (op != OP_NOP7);
   endfunction

   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Magnitude of a 32-bit value; only negates when treated as signed.
   function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? -x : x;
   endfunction

endpackage

// File: rtl/hilo_unit_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit one quotient bit.
module div_step (
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] dvs,
   output logic [31:0] rem_nxt,
   output logic [31:0] quo_nxt
);

   logic [32:0] shifted;
   logic        fits;

   assign shifted = {rem, quo[31]};
   // The remainder stays below the divisor, so a 32-bit subtract is exact when it fits.
   assign fits    = (shifted >= {1'b0, dvs});
   assign rem_nxt = fits ? (shifted[31:0] - dvs) : shifted[31:0];
   assign quo_nxt = {quo[30:0], fits};

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: single-cycle multiply and HI/LO moves, 32-cycle restoring
// divide; hi/lo are plain flops written from a single sequential block.
module hilo_unit
   import hilo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   state_e             state, state_nxt;
   op_e                op_sel;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        rem_q, quo_q, dvs_q;
   logic [31:0]        rem_nxt, quo_nxt;
   logic               neg_q, neg_r;
   logic               accept, last_step, signed_div;
   logic [63:0]        prod_s, prod_u;

   assign op_sel     = op_e'(op);
   assign busy       = (state == ST_DIV);
   assign accept     = start && !busy && op_is_valid(op_sel);
   assign last_step  = (cnt == CNT_W'(DIV_CYCLES - 1));
   assign signed_div = (op_sel == OP_DIV);

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   div_step u_div_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .dvs     (dvs_q),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept && op_is_div(op_sel)) state_nxt = ST_DIV;
         ST_DIV:  if (last_step)                   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            case (op_sel)
               OP_MULT: begin
                  {hi, lo} <= prod_s;
                  done     <= 1'b1;
               end
               OP_MULTU: begin
                  {hi, lo} <= prod_u;
                  done     <= 1'b1;
               end
               OP_MTHI: begin
                  hi   <= a;
                  done <= 1'b1;
               end
               OP_MTLO: begin
                  lo   <= a;
                  done <= 1'b1;
               end
               OP_DIV, OP_DIVU: begin
                  cnt   <= '0;
                  rem_q <= '0;
                  quo_q <= mag32(a, signed_div);
                  dvs_q <= mag32(b, signed_div);
                  // Divide by zero keeps the all-ones quotient unsigned.
                  neg_q <= signed_div && (a[31] ^ b[31]) && (b != 32'd0);
                  neg_r <= signed_div && a[31];
               end
               default: ;
            endcase
         end else if (busy) begin
            cnt   <= cnt + CNT_W'(1);
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (last_step) begin
               lo   <= neg_q ? -quo_nxt : quo_nxt;
               hi   <= neg_r ? -rem_nxt : rem_nxt;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: transaction-level reference model
// compared every cycle, directed literal cases, then randomized traffic.
module tb_hilo_unit;

   localparam logic [2:0] MULT  = 3'b000;
   localparam logic [2:0] MULTU = 3'b001;
   localparam logic [2:0] DIV   = 3'b010;
   localparam logic [2:0] DIVU  = 3'b011;
   localparam logic [2:0] MTHI  = 3'b100;
   localparam logic [2:0] MTLO  = 3'b101;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int n_checks = 0;
   int n_errors = 0;

   hilo_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results computed with plain arithmetic at acceptance,
   // released after the divide latency.
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_done = 1'b0;
   int          m_left = 0;
   longint      sa, sb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
         end else if (start && op <= 3'd5) begin
            m_done = 1'b1;
            case (op)
               MULT:  {m_hi, m_lo} = longint'($signed(a)) * longint'($signed(b));
               MULTU: {m_hi, m_lo} = longint'({32'd0, a}) * longint'({32'd0, b});
               MTHI:  m_hi = a;
               MTLO:  m_lo = a;
               DIV, DIVU: begin
                  if (b == 32'd0) begin
                     p_lo = 32'hFFFF_FFFF; p_hi = a;
                  end else if (op == DIV) begin
                     sa = longint'($signed(a)); sb = longint'($signed(b));
                     p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
                  end else begin
                     p_lo = a / b; p_hi = a % b;
                  end
                  m_left = 32; m_done = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (!rst) begin
         check("model_hi",   {32'd0, hi}, {32'd0, m_hi});
         check("model_lo",   {32'd0, lo}, {32'd0, m_lo});
         check("model_busy", 64'(busy),   64'(m_left > 0));
         check("model_done", 64'(done),   64'(m_done));
      end
   end

   task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic run_div(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int nb = 0;
      drive(o, x, y);
      for (int i = 0; i < 32; i++) begin
         if (busy) nb++;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, 64'(nb), 64'd32);
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_busy_end"}, 64'(busy), 64'd0);
      check({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
      check({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_hi",   {32'd0, hi}, 64'd0);
      check("reset_lo",   {32'd0, lo}, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      drive(MTHI, 32'h1234, 32'd0);
      check("mthi_hi",   {32'd0, hi}, 64'h1234);
      check("mthi_done", 64'(done), 64'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_hi",   {32'd0, hi}, 64'd0);
      check("async_rst_lo",   {32'd0, lo}, 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      drive(MULT, 32'hFFFF_FFFE, 32'd3);
      check("mult_hi",   {32'd0, hi}, 64'hFFFF_FFFF);
      check("mult_lo",   {32'd0, lo}, 64'hFFFF_FFFA);
      check("mult_done", 64'(done), 64'd1);
      check("mult_busy", 64'(busy), 64'd0);
      drive(MULTU, 32'hFFFF_FFFE, 32'd3);
      check("multu_hi", {32'd0, hi}, 64'h0000_0002);
      check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFA);

      run_div("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div("divu_5_0",   DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run_div("div_min_m1", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      @(negedge clk);
      check("done_single_cycle", 64'(done), 64'd0);

      drive(DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1; op = MULT; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (22) @(negedge clk);
      check("ign_mult_done", 64'(done), 64'd1);
      check("ign_mult_lo",   {32'd0, lo}, 64'd14);
      check("ign_mult_hi",   {32'd0, hi}, 64'd2);
      drive(MTLO, 32'hABCD, 32'd0);
      check("mtlo_lo", {32'd0, lo}, 64'hABCD);
      check("mtlo_hi", {32'd0, hi}, 64'd2);

      drive(3'b110, 32'd55, 32'd66);
      check("nop_done", 64'(done), 64'd0);
      check("nop_lo",   {32'd0, lo}, 64'hABCD);

      drive(DIV, 32'h0000_1000, 32'd7);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_hi",   {32'd0, hi}, 64'd0);
      check("abort_lo",   {32'd0, lo}, 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 64'(done), 64'd0);
      end
      run_div("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            start = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         start = ($urandom_range(0, 2) == 0);
         op    = 3'($urandom_range(0, 7));
         a     = pick();
         b     = pick();
         @(negedge clk);
      end
      start = 1'b0;
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
